// File: rtl/saber_pkg.sv
// Shared constants, state encoding and the negacyclic secret rotation for the Saber MAC sequencer.
package saber_pkg;

    localparam int SABER_N     = 256;
    localparam int SABER_QW    = 13;
    localparam int SABER_SW    = 4;
    localparam int SABER_CNT_W = $clog2(SABER_N);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Multiply by x modulo x^N+1: shift lanes up one, the lane wrapping into 0 is negated
    // by flipping its sign bit (sign-magnitude secret).
    function automatic logic [SABER_N*SABER_SW-1:0] rot_secret(
        input logic [SABER_N*SABER_SW-1:0] s
    );
        logic [SABER_SW-1:0] w_top;
        w_top = s[SABER_N*SABER_SW-1 -: SABER_SW];
        w_top[SABER_SW-1] = ~w_top[SABER_SW-1];
        return {s[(SABER_N-1)*SABER_SW-1:0], w_top};
    endfunction

endpackage

// File: rtl/saber_mac_sequencer_secret_rotator.sv
// Combinational negacyclic rotation of the packed secret polynomial.
module secret_rotator
    import saber_pkg::*;
(
    input  logic [SABER_N*SABER_SW-1:0] i_secret,
    output logic [SABER_N*SABER_SW-1:0] o_secret
);

    assign o_secret = rot_secret(i_secret);

endmodule

// File: rtl/saber_mac_sequencer.sv
// Sequencer/accumulator around the 256-lane Saber MAC array.
// Optional build macro SABER_MAC_ACCUM_EN adds accum_i to keep the accumulator across starts.
module saber_mac_sequencer
    import saber_pkg::*;
#(
    parameter int N  = SABER_N,
    parameter int QW = SABER_QW,
    parameter int SW = SABER_SW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [N*SW-1:0] secret_i,
`ifdef SABER_MAC_ACCUM_EN
    input  logic            accum_i,
`endif
    input  logic            a_valid_i,
    input  logic [QW-1:0]   a_data_i,
    output logic            a_ready_o,
    output logic [N*QW-1:0] mac_acc_o,
    output logic [N*SW-1:0] mac_secret_o,
    output logic [QW-1:0]   mac_coeff_o,
    input  logic [N*QW-1:0] mac_result_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [N*QW-1:0] acc_o
);

    localparam int         CNT_W  = $clog2(N);
    localparam logic [0:0] S_IDLE = ST_IDLE;
    localparam logic [0:0] S_RUN  = ST_RUN;

    logic [0:0]      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [N*QW-1:0] r_acc;
    logic [N*SW-1:0] r_secret;
    logic            r_done;

    logic            w_run;
    logic            w_hs;
    logic            w_clear_acc;
    logic [N*SW-1:0] w_secret_rot;

    // Handshake: a coefficient is consumed on a rising edge where a_valid_i and a_ready_o are both high.
    assign w_run = (r_state == S_RUN);
    assign w_hs  = a_valid_i & w_run;

`ifdef SABER_MAC_ACCUM_EN
    assign w_clear_acc = ~accum_i;
`else
    assign w_clear_acc = 1'b1;
`endif

    secret_rotator u_rot (
        .i_secret (r_secret),
        .o_secret (w_secret_rot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_secret <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_secret <= secret_i;
                        r_cnt    <= '0;
                        r_state  <= S_RUN;
                        if (w_clear_acc) begin
                            r_acc <= '0;
                        end
                    end
                end
                default: begin
                    if (w_hs) begin
                        r_acc    <= mac_result_i;
                        r_secret <= w_secret_rot;
                        r_cnt    <= r_cnt + 1'b1;
                        // Counter wraps to zero on the last coefficient by itself.
                        if (r_cnt == CNT_W'(N - 1)) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign a_ready_o    = w_run;
    assign busy_o       = w_run;
    assign done_o       = r_done;
    assign acc_o        = r_acc;
    assign mac_acc_o    = r_acc;
    assign mac_secret_o = r_secret;
    assign mac_coeff_o  = a_data_i;

endmodule

// File: tb/tb_saber_mac_sequencer.sv
// Self-checking bench: models the external MAC array and a schoolbook negacyclic product.
module tb_saber_mac_sequencer;

    localparam int N  = 256;
    localparam int QW = 13;
    localparam int SW = 4;

    logic            clk;
    logic            rst_n;
    logic            start_i;
    logic [N*SW-1:0] secret_i;
`ifdef SABER_MAC_ACCUM_EN
    logic            accum_v;
`endif
    logic            a_valid_i;
    logic [QW-1:0]   a_data_i;
    logic            a_ready_o;
    logic [N*QW-1:0] mac_acc_o;
    logic [N*SW-1:0] mac_secret_o;
    logic [QW-1:0]   mac_coeff_o;
    logic [N*QW-1:0] mac_result_i;
    logic            busy_o;
    logic            done_o;
    logic [N*QW-1:0] acc_o;

    int n_tests = 0;
    int n_fail  = 0;
    int done_count = 0;

    logic [QW-1:0] exp_q[$];
    logic [QW-1:0] a_vec[N];
    logic [QW-1:0] prev_c[N];

    saber_mac_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .secret_i     (secret_i),
`ifdef SABER_MAC_ACCUM_EN
        .accum_i      (accum_v),
`endif
        .a_valid_i    (a_valid_i),
        .a_data_i     (a_data_i),
        .a_ready_o    (a_ready_o),
        .mac_acc_o    (mac_acc_o),
        .mac_secret_o (mac_secret_o),
        .mac_coeff_o  (mac_coeff_o),
        .mac_result_i (mac_result_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .acc_o        (acc_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    always @(posedge clk) begin
        if (rst_n && done_o) done_count <= done_count + 1;
    end

    // external MAC array: result = acc +/- a * |s|, mod 2^13
    function automatic logic [QW-1:0] lane_mac(input logic [QW-1:0] acc, input logic [SW-1:0] s,
                                               input logic [QW-1:0] a);
        logic [QW-1:0] p;
        p = a * QW'(s[2:0]);
        return s[3] ? acc - p : acc + p;
    endfunction

    always_comb begin
        mac_result_i = '0;
        for (int i = 0; i < N; i++) begin
            mac_result_i[i*QW +: QW] = lane_mac(mac_acc_o[i*QW +: QW], mac_secret_o[i*SW +: SW], mac_coeff_o);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // schoolbook c[i] = sum_j a_j * s[i-j], negated where i-j wraps
    task automatic push_expected(input logic [N*SW-1:0] sec, input bit accum);
        int c, k, sv;
        logic [SW-1:0] s;
        for (int i = 0; i < N; i++) begin
            c = accum ? int'(prev_c[i]) : 0;
            for (int j = 0; j < N; j++) begin
                k = i - j;
                s = (k >= 0) ? sec[k*SW +: SW] : sec[(k+N)*SW +: SW];
                sv = int'(s[2:0]);
                if (s[3]) sv = -sv;
                if (k < 0) sv = -sv;
                c = c + int'(a_vec[j]) * sv;
            end
            prev_c[i] = QW'(c & 8191);
            exp_q.push_back(prev_c[i]);
        end
    endtask

    task automatic compare_result(input string name);
        logic [QW-1:0] e;
        check({name, "_sb_depth"}, exp_q.size(), N);
        for (int i = 0; i < N; i++) begin
            if (exp_q.size() == 0) break;
            e = exp_q.pop_front();
            check($sformatf("%s_lane%0d", name, i), acc_o[i*QW +: QW], e);
        end
        exp_q.delete();
    endtask

    // driver: one full multiplication
    task automatic do_run(input logic [N*SW-1:0] sec, input bit accum, input bit stall,
                          input bit poke, input string name);
        int j, cyc, done_before;
        bit valid, hs;
        push_expected(sec, accum);
        done_before = done_count;
        @(negedge clk);
        start_i  = 1'b1;
        secret_i = sec;
`ifdef SABER_MAC_ACCUM_EN
        accum_v  = accum;
`endif
        @(negedge clk);
        start_i = 1'b0;
        check({name, "_ready_after_start"}, a_ready_o, 1);
        check({name, "_busy_after_start"}, busy_o, 1);
        check({name, "_secret_loaded"}, mac_secret_o == sec, 1);
        j = 0;
        cyc = 0;
        while (j < N && cyc < 3000) begin
            valid     = !(stall && (cyc % 3 == 2));
            a_valid_i = valid;
            a_data_i  = a_vec[j];
            start_i   = poke && (cyc == 5 || (j == N - 1 && valid));
            hs        = valid && a_ready_o;
            if (cyc == 7) begin
                #1;
                check({name, "_coeff_pass"}, mac_coeff_o, a_data_i);
                check({name, "_mac_acc_eq"}, mac_acc_o == acc_o, 1);
            end
            @(negedge clk);
            start_i = 1'b0;
            if (hs) j++;
            cyc++;
        end
        a_valid_i = 1'b0;
        check({name, "_handshakes"}, j, N);
        if (!stall) check({name, "_run_len"}, cyc, N);
        check({name, "_done_pulse"}, done_o, 1);
        check({name, "_busy_end"}, busy_o, 0);
        compare_result(name);
        @(negedge clk);
        check({name, "_done_one_cycle"}, done_o, 0);
        check({name, "_idle_ready"}, a_ready_o, 0);
        @(negedge clk);
        check({name, "_done_count"}, done_count - done_before, 1);
    endtask

    initial begin
        logic [N*SW-1:0] sec;
        rst_n     = 1'b0;
        start_i   = 1'b0;
        secret_i  = '0;
        a_valid_i = 1'b0;
        a_data_i  = '0;
`ifdef SABER_MAC_ACCUM_EN
        accum_v   = 1'b0;
`endif
        for (int i = 0; i < N; i++) prev_c[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_ready", a_ready_o, 0);
        check("rst_done", done_o, 0);
        check("rst_acc", |acc_o, 0);
        check("rst_secret", |mac_secret_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // reset mid-run after 10 handshakes
        sec = '0;
        sec[SW-1:0] = 4'b0001;
        @(negedge clk);
        start_i  = 1'b1;
        secret_i = sec;
        @(negedge clk);
        start_i   = 1'b0;
        a_valid_i = 1'b1;
        a_data_i  = 13'd5;
        repeat (10) @(negedge clk);
        check("pre_rst_busy", busy_o, 1);
        check("pre_rst_acc_nz", |acc_o, 1);
        rst_n     = 1'b0;
        a_valid_i = 1'b0;
        #1;
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_ready", a_ready_o, 0);
        check("mid_rst_acc", |acc_o, 0);
        @(negedge clk);
        check("mid_rst_acc_next", |acc_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // s[0]=+1, a_j=j+1
        for (int j = 0; j < N; j++) a_vec[j] = QW'(j + 1);
        do_run(sec, 1'b0, 1'b0, 1'b0, "ident");

        // s[255]=+1, a_1=1: wraps to -1 in lane 0
        sec = '0;
        sec[(N-1)*SW +: SW] = 4'b0001;
        for (int j = 0; j < N; j++) a_vec[j] = '0;
        a_vec[1] = 13'd1;
        do_run(sec, 1'b0, 1'b0, 1'b0, "wrap");

        // random secret/coefficients with stalls, then again with start pokes
        for (int i = 0; i < N; i++) begin
            sec[i*SW +: SW] = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 4))};
        end
        for (int j = 0; j < N; j++) a_vec[j] = QW'($urandom_range(0, 8191));
        do_run(sec, 1'b0, 1'b1, 1'b0, "rand_stall");
        do_run(sec, 1'b0, 1'b0, 1'b1, "rand_poke");

`ifdef SABER_MAC_ACCUM_EN
        sec = '0;
        sec[SW-1:0] = 4'b0001;
        for (int j = 0; j < N; j++) a_vec[j] = 13'd1;
        do_run(sec, 1'b0, 1'b0, 1'b0, "acc_first");
        do_run(sec, 1'b1, 1'b0, 1'b0, "acc_keep");
        do_run(sec, 1'b0, 1'b0, 1'b0, "acc_clear");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
